// File: rtl/scr1_dmi_arb_if.sv
// DMI arbiter bundle: two host request channels plus the DM-side request port.
// slave = arbiter view, master = hosts/DM view.
interface scr1_dmi_arb_if;
    logic        host0_req_i;
    logic        host0_wr_i;
    logic [6:0]  host0_addr_i;
    logic [31:0] host0_wdata_i;
    logic        host0_resp_o;
    logic        host0_err_o;
    logic        host1_req_i;
    logic        host1_wr_i;
    logic [6:0]  host1_addr_i;
    logic [31:0] host1_wdata_i;
    logic        host1_resp_o;
    logic        host1_err_o;
    logic [31:0] host_rdata_o;
    logic        dmi2dm_req_o;
    logic        dmi2dm_wr_o;
    logic [6:0]  dmi2dm_addr_o;
    logic [31:0] dmi2dm_wdata_o;
    logic        dm2dmi_resp_i;
    logic [31:0] dm2dmi_rdata_i;
    logic        arb_busy_o;

    modport slave (
        input  host0_req_i, host0_wr_i, host0_addr_i, host0_wdata_i,
        input  host1_req_i, host1_wr_i, host1_addr_i, host1_wdata_i,
        input  dm2dmi_resp_i, dm2dmi_rdata_i,
        output host0_resp_o, host0_err_o, host1_resp_o, host1_err_o,
        output host_rdata_o, dmi2dm_req_o, dmi2dm_wr_o, dmi2dm_addr_o,
        output dmi2dm_wdata_o, arb_busy_o
    );

    modport master (
        output host0_req_i, host0_wr_i, host0_addr_i, host0_wdata_i,
        output host1_req_i, host1_wr_i, host1_addr_i, host1_wdata_i,
        output dm2dmi_resp_i, dm2dmi_rdata_i,
        input  host0_resp_o, host0_err_o, host1_resp_o, host1_err_o,
        input  host_rdata_o, dmi2dm_req_o, dmi2dm_wr_o, dmi2dm_addr_o,
        input  dmi2dm_wdata_o, arb_busy_o
    );
endinterface

// File: rtl/scr1_dmi_arb.sv
// Round-robin two-host arbiter/sequencer for the DM's DMI request port.
// Optional ISSUE timeout enabled by defining SCR1_DMI_ARB_TIMEOUT_EN.
module scr1_dmi_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic            clk,
    input logic            rst_n,
    scr1_dmi_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_gnt;
    logic        gnt;
    logic        sel1;
    logic        any_req;
    logic        tmo;
    logic        lat_wr;
    logic [6:0]  lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] rdata;
    logic        err_q;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    assign any_req = bus.host0_req_i | bus.host1_req_i;
    // Port 1 wins alone, or under contention when port 0 was served last.
    assign sel1    = bus.host1_req_i & (~bus.host0_req_i | ~last_gnt);

`ifdef SCR1_DMI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    assign tmo = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count cycles spent in ISSUE; zero whenever we are elsewhere.
    always_ff @(posedge clk) begin
        if (!rst_n || state != ISSUE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: grant, wait for the DM (or timeout), pulse response.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   if (bus.dm2dmi_resp_i || tmo) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winner's command and the outcome of the access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt  <= 1'b1;
            gnt       <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt       <= sel1;
                        last_gnt  <= sel1;
                        lat_wr    <= sel1 ? bus.host1_wr_i    : bus.host0_wr_i;
                        lat_addr  <= sel1 ? bus.host1_addr_i  : bus.host0_addr_i;
                        lat_wdata <= sel1 ? bus.host1_wdata_i : bus.host0_wdata_i;
                    end
                end
                ISSUE: begin
                    if (bus.dm2dmi_resp_i) begin
                        rdata <= lat_wr ? 32'h0 : bus.dm2dmi_rdata_i;
                        err_q <= 1'b0;
                    end else if (tmo) begin
                        rdata <= 32'h0;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dmi2dm_req_o   = (state == ISSUE);
    assign bus.dmi2dm_wr_o    = bus.dmi2dm_req_o & lat_wr;
    assign bus.dmi2dm_addr_o  = bus.dmi2dm_req_o ? lat_addr  : 7'h0;
    assign bus.dmi2dm_wdata_o = bus.dmi2dm_req_o ? lat_wdata : 32'h0;
    assign bus.host0_resp_o   = (state == RESP) & ~gnt;
    assign bus.host1_resp_o   = (state == RESP) &  gnt;
    assign bus.host0_err_o    = bus.host0_resp_o & err_q;
    assign bus.host1_err_o    = bus.host1_resp_o & err_q;
    assign bus.host_rdata_o   = rdata;
    assign bus.arb_busy_o     = (state != IDLE);

endmodule

// File: doc/scr1_dmi_arb.md
# scr1_dmi_arb

Two-port arbiter and sequencer for the Debug Module's DMI request port. It sits between the DM and two DMI hosts: port 0 is the JTAG DMI channel and port 1 is an auxiliary host, such as a UART debug bridge. It serialises their accesses with round-robin fairness and holds each command stable until the DM responds. It returns the response and read data to the granted host only.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles in ISSUE before forced completion; must be ≥ 2. Used only with SCR1_DMI_ARB_TIMEOUT_EN.

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low, sampled on the clk rising edge.
- host0_req_i / host1_req_i  in  1  request; held high with stable fields until the matching resp pulse.
- host0_wr_i / host1_wr_i  in  1  1 = write, 0 = read.
- host0_addr_i / host1_addr_i  in  7  DMI address.
- host0_wdata_i / host1_wdata_i  in  32  write data.
- host0_resp_o / host1_resp_o  out  1  one-cycle completion pulse.
- host0_err_o / host1_err_o  out  1  error qualifier, valid with resp.
- host_rdata_o  out  32  read data, shared by both hosts, valid with either resp pulse.
- dmi2dm_req_o  out  1  request to the DM.
- dmi2dm_wr_o  out  1  write strobe.
- dmi2dm_addr_o  out  7  address.
- dmi2dm_wdata_o  out  32  write data.
- dm2dmi_resp_i  in  1  DM response.
- dm2dmi_rdata_i  in  32  DM read data.
- arb_busy_o  out  1  high in ISSUE or RESP.

## Operation
- FSM states:
  - IDLE: sample the requests. If any request is high, latch the winner's wr/addr/wdata and its grant index, then go to ISSUE.
  - ISSUE: drive dmi2dm_req_o=1 with the latched fields.
    - On dm2dmi_resp_i: capture rdata into host_rdata_o if the access is a read (0 for a write), then go to RESP.
    - On timeout (see Configuration): go to RESP with the error flag set.
  - RESP: pulse resp_o, plus err_o if flagged, on the granted port only, then go to IDLE.
- Arbitration:
  - A single request wins.
  - When both requests are high, the port other than the last-granted one wins.
  - Last-granted resets to 1, so port 0 wins the first contention.
  - The pointer updates on each grant.
- dmi2dm_wr/addr/wdata_o are 0 whenever dmi2dm_req_o=0.
- host_rdata_o holds its value outside RESP. It is 0 after a write or a timed-out access.
- Requests in the RESP cycle are ignored. A host must drop its request in the cycle after its resp pulse; a request still high in IDLE is treated as a new access.
- The request fields of a non-granted port are never sampled.

## Timing
- Reset values: FSM=IDLE, pointer=1, and all outputs 0 (resp, err, rdata, dmi2dm_*, arb_busy_o).
- Latency with a zero-wait DM:
  - Request high in cycle N.
  - dmi2dm_req_o high in cycle N+1; the DM responds in that cycle.
  - resp_o high in cycle N+2.
  - Next grant possible in cycle N+3.
- Each DM wait cycle adds one cycle of latency.
- Throughput: one access per 3 cycles at best.
- dm2dmi_resp_i is ignored outside ISSUE.
- Synchronous reset in any state returns to IDLE on that edge. The in-flight access is dropped with no resp pulse.

## Configuration
- Macro SCR1_DMI_ARB_TIMEOUT_EN.
- Defined:
  - The ISSUE cycle counter is $clog2(TIMEOUT_CYCLES+1) bits, cleared when entering ISSUE.
  - When the counter reaches TIMEOUT_CYCLES-1 with no response, the FSM goes to RESP with err=1, rdata=0, and the next cycle has dmi2dm_req_o=0.
  - A response in the same cycle as expiry wins: completion is normal with err=0.
- Undefined: no counter exists, ISSUE waits indefinitely, and err_o is tied to 0.

## Test plan
- Host0 read of addr 0x11, DM responds in the first ISSUE cycle with 0xDEADBEEF -> dmi2dm_req_o in cycle 1 with wr=0 and addr=0x11; host0_resp_o and host_rdata_o=0xDEADBEEF in cycle 2; host1_resp_o stays 0.
- Both hosts request at once, host1 writing 0x12345678 to 0x10 -> host0 is served first. Host1 is issued next with wr=1, addr=0x10, wdata=0x12345678, and its resp shows rdata=0.
- Both hosts hold continuous back-to-back requests for 6 accesses -> grants alternate 0,1,0,1,0,1.
- The DM delays its response by 5 cycles -> the dmi2dm fields stay stable for 6 cycles and resp arrives 5 cycles late.
- With the macro and TIMEOUT_CYCLES=4, the DM never responds:
  - host1 gets resp=1, err=1, rdata=0 exactly 4 cycles after ISSUE entry.
  - Repeat with the response on the last cycle: err=0.
- rst_n is asserted low for one edge during ISSUE -> the next cycle has all outputs 0 and the FSM in IDLE with no resp pulse. After release, a contended request grants port 0.
